wb_mem_arbiter: RTL and testbench
=================================

Name: wb_mem_arbiter

Overview:
- Two-master, one-slave Wishbone-style arbiter that shares the single memory port between the cpu (master 0) and a program loader/debug master (master 1).
- Each master's single-cycle strobe is captured into a per-master request slot. Slots are issued to the slave one at a time under round-robin priority.
- The slave's ack and read data are returned only to the master that owns the transaction.
- A timeout counter returns an error ack if the slave never acks, so a dead slave cannot hang the cpu.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SEL_W, 3, select/size field width (funct3 encoding, passed through unchanged).
- TIMEOUT, 16, max cycles in S_WAIT before error completion; legal range 2..255.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_m0_stb  in  1  cpu request strobe (one-cycle pulse).
- i_m0_we  in  1  cpu write enable.
- i_m0_addr  in  ADDR_W  cpu address.
- i_m0_data  in  DATA_W  cpu write data.
- i_m0_sel  in  SEL_W  cpu size select.
- o_m0_data  out  DATA_W  read data to cpu.
- o_m0_ack  out  1  completion pulse to cpu.
- o_m0_stall  out  1  cpu slot occupied.
- o_m0_err  out  1  qualifies o_m0_ack: completion was a timeout.
- i_m1_stb, i_m1_we, i_m1_addr, i_m1_data, i_m1_sel  in  as m0  loader request.
- o_m1_data, o_m1_ack, o_m1_stall, o_m1_err  out  as m0  loader response.
- o_s_stb  out  1  slave strobe (one-cycle pulse).
- o_s_we  out  1  slave write enable.
- o_s_addr  out  ADDR_W  slave address.
- o_s_data  out  DATA_W  slave write data.
- o_s_sel  out  SEL_W  slave select.
- i_s_data  in  DATA_W  slave read data.
- i_s_ack  in  1  slave completion.
- i_s_stall  in  1  slave cannot accept a strobe.
- o_grant  out  1  owner of the current or last transaction (0 = cpu).

Behaviour:
- Reset (async, i_reset_n=0):
  - All stb/ack/stall/err/we outputs are 0.
  - o_s_addr, o_s_data, o_m*_data are all-ones; o_s_sel is 0.
  - Both slots are empty; state is S_IDLE; timeout counter is 0.
  - last_grant=1, so m0 wins the first tie; o_grant=1.
- Capture: on an edge where i_mX_stb=1 and o_mX_stall=0:
  - latch we/addr/data/sel into slot X;
  - set pending_X;
  - o_mX_stall<=1.
  - A strobe while o_mX_stall=1 is a protocol violation; it is dropped and has no effect.
- States:
  - S_IDLE, S_WAIT.
  - The rest of this list (S_ISSUE, S_DONE) is a packaging typo and was not part of the decided state set; only S_IDLE and S_WAIT exist.
- S_IDLE: if any slot is pending and i_s_stall=0:
  - pick the grant: if only one slot is pending, that one; if both are pending, the one != last_grant;
  - drive o_s_* from that slot and set o_s_stb<=1;
  - o_grant<=g; counter<=0; go to S_WAIT.
  - A slot captured on edge N is issued at the earliest on edge N+1.
- S_WAIT:
  - o_s_stb<=0 unconditionally, so the strobe is exactly one cycle.
  - If i_s_ack:
    - o_mg_ack<=1 and o_mg_data<=i_s_data (data updated for writes too);
    - o_mg_err<=0; clear pending_g; o_mg_stall<=0;
    - last_grant<=g; go to S_IDLE.
  - Else if counter==TIMEOUT-1:
    - the same completion, but o_mg_err<=1 and o_mg_data<=all-ones.
  - Else counter<=counter+1.
- Ack timing: o_mX_ack and o_mX_err are high for exactly one cycle, cleared on the next edge.
  - The freed slot can capture a new strobe on the edge after the ack edge.
- Minimum round trip for a slave that acks in the cycle after stb is 3 edges from master strobe to master ack.
- Simultaneous events:
  - A capture on slot X on the same edge that completes slot Y is allowed.
  - A new capture never affects the transaction in flight.
- i_s_ack in S_IDLE (spurious or late after a timeout) is ignored.
- i_s_stall only gates issue; it is ignored in S_WAIT.
- Reset mid-transaction abandons the slave access. No ack is generated to either master.

Decomposition:
- Shared package (arb_pkg):
  - state encodings S_IDLE, S_WAIT;
  - ERR_DATA (all-ones) constant;
  - default TIMEOUT.
- Sub-module wb_req_slot, instantiated once per master:
  - pending flag, latched we/addr/data/sel, stall output;
  - inputs: stb, clear.
- Grant selection, counter and state machine stay in wb_mem_arbiter.

Test Plan:
- Single cpu read:
  - Stimulus: m0 stb, addr=0x10; slave acks 1 cycle after o_s_stb with data 0xDEADBEEF.
  - Required: o_s_addr=0x10, o_s_we=0; o_m0_ack pulse with o_m0_data=0xDEADBEEF and err=0; o_m0_stall falls with the ack; m1 outputs stay 0.
- Simultaneous strobes:
  - Stimulus: m0 write 0x5 to 0x20 and m1 read 0x40 on the same edge, just after reset.
  - Required: slave sees 0x20 first, then 0x40; on the next tie m1 wins.
- Slave stall:
  - Stimulus: i_s_stall=1 for 4 cycles after a pending m1 request.
  - Required: no o_s_stb during the stall; issue on the first edge with stall=0; exactly one stb pulse.
- Timeout:
  - Stimulus: slave never acks, TIMEOUT=16.
  - Required: o_m0_ack with o_m0_err=1 and data 0xFFFFFFFF, 16 edges after issue. A later i_s_ack is ignored and no extra ack appears.
- Stall violation:
  - Stimulus: m0 strobes again while o_m0_stall=1, with a different addr.
  - Required: only the first address reaches the slave.
- Async reset mid-S_WAIT:
  - Stimulus: assert i_reset_n=0 between edges.
  - Required: all outputs go to reset values immediately. The slave ack arriving after release produces no master ack.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared state encodings, constants and grant helper for the Wishbone arbiter
package arb_pkg;
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    localparam int TIMEOUT_DEF = 16;
    localparam logic [63:0] ERR_DATA = '1;
    // On a tie, the master that did not own the last transaction wins
    function automatic logic pick_grant(input logic p0, input logic p1, input logic last);
        return (p0 && p1) ? ~last : p1;
    endfunction
endpackage

// File: rtl/wb_req_slot.sv
// wb_req_slot: holds one master's captured request until the arbiter completes it
module wb_req_slot #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic              i_clear,
    output logic              o_stall,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [SEL_W-1:0]  o_sel
);
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_stall <= 1'b0;
            o_we    <= 1'b0;
            o_addr  <= '0;
            o_data  <= '0;
            o_sel   <= '0;
        end else if (i_stb && !o_stall) begin
            o_stall <= 1'b1;
            o_we    <= i_we;
            o_addr  <= i_addr;
            o_data  <= i_data;
            o_sel   <= i_sel;
        end else if (i_clear) begin
            o_stall <= 1'b0;
        end
    end
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin two-master to one-slave Wishbone arbiter with ack timeout
module wb_mem_arbiter import arb_pkg::*; #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_m0_stb,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_data,
    input  logic [SEL_W-1:0]  i_m0_sel,
    output logic [DATA_W-1:0] o_m0_data,
    output logic              o_m0_ack,
    output logic              o_m0_stall,
    output logic              o_m0_err,
    input  logic              i_m1_stb,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_data,
    input  logic [SEL_W-1:0]  i_m1_sel,
    output logic [DATA_W-1:0] o_m1_data,
    output logic              o_m1_ack,
    output logic              o_m1_stall,
    output logic              o_m1_err,
    output logic              o_s_stb,
    output logic              o_s_we,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic [DATA_W-1:0] o_s_data,
    output logic [SEL_W-1:0]  o_s_sel,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic              i_s_ack,
    input  logic              i_s_stall,
    output logic              o_grant
);
    localparam logic [DATA_W-1:0] ERR = ERR_DATA[DATA_W-1:0];
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t state, state_d;
    logic [7:0] cnt;
    logic last_grant, g_pick, issue, done, tmo, clr0, clr1;
    logic s0_we, s1_we;
    logic [ADDR_W-1:0] s0_addr, s1_addr;
    logic [DATA_W-1:0] s0_data, s1_data;
    logic [SEL_W-1:0] s0_sel, s1_sel;

    wb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) u_slot0 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stb(i_m0_stb), .i_we(i_m0_we),
        .i_addr(i_m0_addr), .i_data(i_m0_data), .i_sel(i_m0_sel), .i_clear(clr0),
        .o_stall(o_m0_stall), .o_we(s0_we), .o_addr(s0_addr), .o_data(s0_data), .o_sel(s0_sel)
    );

    wb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) u_slot1 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stb(i_m1_stb), .i_we(i_m1_we),
        .i_addr(i_m1_addr), .i_data(i_m1_data), .i_sel(i_m1_sel), .i_clear(clr1),
        .o_stall(o_m1_stall), .o_we(s1_we), .o_addr(s1_addr), .o_data(s1_data), .o_sel(s1_sel)
    );

    always_comb begin
        g_pick  = pick_grant(o_m0_stall, o_m1_stall, last_grant);
        issue   = (state == S_IDLE) && (o_m0_stall || o_m1_stall) && !i_s_stall;
        tmo     = (state == S_WAIT) && !i_s_ack && (cnt == TMO_LAST);
        done    = (state == S_WAIT) && (i_s_ack || tmo);
        clr0    = done && !o_grant;
        clr1    = done && o_grant;
        state_d = issue ? S_WAIT : (done ? S_IDLE : state);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_IDLE;
        else state <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_s_stb    <= 1'b0;
            o_s_we     <= 1'b0;
            o_s_addr   <= '1;
            o_s_data   <= '1;
            o_s_sel    <= '0;
            o_grant    <= 1'b1;
            last_grant <= 1'b1;
            cnt        <= '0;
            o_m0_ack   <= 1'b0;
            o_m1_ack   <= 1'b0;
            o_m0_err   <= 1'b0;
            o_m1_err   <= 1'b0;
            o_m0_data  <= '1;
            o_m1_data  <= '1;
        end else begin
            o_s_stb  <= issue;
            o_m0_ack <= clr0;
            o_m1_ack <= clr1;
            o_m0_err <= clr0 && tmo;
            o_m1_err <= clr1 && tmo;
            cnt      <= issue ? 8'd0 : (state == S_WAIT ? cnt + 8'd1 : cnt);
            if (issue) begin
                o_grant  <= g_pick;
                o_s_we   <= g_pick ? s1_we : s0_we;
                o_s_addr <= g_pick ? s1_addr : s0_addr;
                o_s_data <= g_pick ? s1_data : s0_data;
                o_s_sel  <= g_pick ? s1_sel : s0_sel;
            end
            if (done) last_grant <= o_grant;
            if (clr0) o_m0_data <= tmo ? ERR : i_s_data;
            if (clr1) o_m1_data <= tmo ? ERR : i_s_data;
        end
    end
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: scoreboard bench; expected slave strobes and master completions are queued by stimulus
module tb_wb_mem_arbiter;
    typedef struct {logic we; logic [31:0] addr; logic [31:0] data; logic [2:0] sel; int cyc;} slv_t;
    typedef struct {int m; logic [31:0] data; logic err; int cyc;} done_t;

    logic i_clk, i_reset_n;
    logic i_m0_stb, i_m0_we, i_m1_stb, i_m1_we;
    logic [31:0] i_m0_addr, i_m0_data, i_m1_addr, i_m1_data;
    logic [2:0] i_m0_sel, i_m1_sel;
    logic [31:0] o_m0_data, o_m1_data;
    logic o_m0_ack, o_m0_stall, o_m0_err, o_m1_ack, o_m1_stall, o_m1_err;
    logic o_s_stb, o_s_we;
    logic [31:0] o_s_addr, o_s_data;
    logic [2:0] o_s_sel;
    logic [31:0] i_s_data;
    logic i_s_ack, i_s_stall;
    logic o_grant;

    int checks = 0, errors = 0, cyc = 0, stb_cnt = 0;
    int kick_req = 0, kick_seen = 0;
    bit slv_auto = 1'b0, ack_nxt = 1'b0;
    slv_t sq[$];
    done_t mq[$];

    wb_mem_arbiter dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel),
        .o_m0_data(o_m0_data), .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err),
        .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel),
        .o_m1_data(o_m1_data), .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err),
        .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
        .i_s_data(i_s_data), .i_s_ack(i_s_ack), .i_s_stall(i_s_stall), .o_grant(o_grant)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Slave acks during the cycle after it sees a strobe; kick_req injects a stray ack
    always @(negedge i_clk) begin
        i_s_ack = ack_nxt;
        ack_nxt = (slv_auto && o_s_stb) || (kick_req != kick_seen);
        kick_seen = kick_req;
    end

    task automatic got_done(input int m, input logic [31:0] d, input logic e, input logic st);
        done_t x;
        if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack on m%0d data %0h required no ack", m, d);
        end else begin
            x = mq.pop_front();
            chk("ack_master", m, x.m);
            chk("ack_data", d, x.data);
            chk("ack_err", e, x.err);
            chk("ack_cycle", cyc, x.cyc);
            chk("stall_with_ack", st, 1'b0);
        end
    endtask

    always @(negedge i_clk) begin : mon
        slv_t s;
        if (i_reset_n) begin
            if (o_s_stb) begin
                stb_cnt++;
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_s_stb: got addr %0h required no strobe", o_s_addr);
                end else begin
                    s = sq.pop_front();
                    chk("s_we", o_s_we, s.we);
                    chk("s_addr", o_s_addr, s.addr);
                    chk("s_data", o_s_data, s.data);
                    chk("s_sel", o_s_sel, s.sel);
                    chk("s_cycle", cyc, s.cyc);
                end
            end
            if (o_m0_ack) got_done(0, o_m0_data, o_m0_err, o_m0_stall);
            if (o_m1_ack) got_done(1, o_m1_data, o_m1_err, o_m1_stall);
            if ((o_m0_err && !o_m0_ack) || (o_m1_err && !o_m1_ack)) begin
                checks++;
                errors++;
                $display("FAIL err_without_ack: got err %0b%0b required 00", o_m1_err, o_m0_err);
            end
        end
    end

    task automatic exp_s(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sel, input int c);
        slv_t s;
        s.we = we; s.addr = a; s.data = d; s.sel = sel; s.cyc = c;
        sq.push_back(s);
    endtask

    task automatic exp_d(input int m, input logic [31:0] d, input logic e, input int c);
        done_t x;
        x.m = m; x.data = d; x.err = e; x.cyc = c;
        mq.push_back(x);
    endtask

    task automatic set_m0(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sel);
        i_m0_we = we; i_m0_addr = a; i_m0_data = d; i_m0_sel = sel;
    endtask

    task automatic set_m1(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sel);
        i_m1_we = we; i_m1_addr = a; i_m1_data = d; i_m1_sel = sel;
    endtask

    task automatic pulse(input bit s0, input bit s1, output int cap);
        i_m0_stb = s0;
        i_m1_stb = s1;
        @(posedge i_clk);
        #1;
        cap = cyc;
        i_m0_stb = 1'b0;
        i_m1_stb = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cap, s0;
        i_reset_n = 1'b0;
        i_m0_stb = 0; i_m1_stb = 0; i_s_stall = 0; i_s_data = 32'h0;
        set_m0(0, 0, 0, 0);
        set_m1(0, 0, 0, 0);
        wait_cyc(3);
        chk("rst_s_stb", o_s_stb, 0);
        chk("rst_s_addr", o_s_addr, 32'hFFFFFFFF);
        chk("rst_s_data", o_s_data, 32'hFFFFFFFF);
        chk("rst_s_sel", o_s_sel, 0);
        chk("rst_m0_data", o_m0_data, 32'hFFFFFFFF);
        chk("rst_m1_data", o_m1_data, 32'hFFFFFFFF);
        chk("rst_grant", o_grant, 1);
        chk("rst_flags", {o_m0_ack, o_m0_stall, o_m0_err, o_m1_ack, o_m1_stall, o_m1_err, o_s_we}, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        wait_cyc(1);

        // simultaneous strobes just after reset: m0 first, then m1
        slv_auto = 1; i_s_data = 32'h11111111;
        set_m0(1, 32'h20, 32'h5, 3'd2);
        set_m1(0, 32'h40, 32'h0, 3'd2);
        pulse(1, 1, cap);
        exp_s(1, 32'h20, 32'h5, 3'd2, cap + 1);
        exp_s(0, 32'h40, 32'h0, 3'd2, cap + 4);
        exp_d(0, 32'h11111111, 0, cap + 3);
        exp_d(1, 32'h11111111, 0, cap + 6);
        chk("tie_stalls", {o_m0_stall, o_m1_stall}, 2'b11);
        wait_cyc(10);

        // single cpu read
        i_s_data = 32'hDEADBEEF;
        set_m0(0, 32'h10, 32'h0, 3'd2);
        pulse(1, 0, cap);
        exp_s(0, 32'h10, 32'h0, 3'd2, cap + 1);
        exp_d(0, 32'hDEADBEEF, 0, cap + 3);
        chk("rd_stall_set", o_m0_stall, 1);
        wait_cyc(6);
        chk("rd_m0_stall_clr", o_m0_stall, 0);
        chk("rd_m1_quiet", {o_m1_ack, o_m1_stall, o_m1_err}, 0);
        chk("rd_grant", o_grant, 0);

        // next tie after an m0 transaction goes to m1
        i_s_data = 32'hCAFEF00D;
        set_m0(1, 32'h24, 32'h7, 3'd1);
        set_m1(1, 32'h44, 32'h9, 3'd0);
        pulse(1, 1, cap);
        exp_s(1, 32'h44, 32'h9, 3'd0, cap + 1);
        exp_s(1, 32'h24, 32'h7, 3'd1, cap + 4);
        exp_d(1, 32'hCAFEF00D, 0, cap + 3);
        exp_d(0, 32'hCAFEF00D, 0, cap + 6);
        wait_cyc(10);

        // slave stall holds off issue
        i_s_data = 32'h0BADF00D;
        i_s_stall = 1;
        set_m1(0, 32'h80, 32'h0, 3'd4);
        pulse(0, 1, cap);
        s0 = stb_cnt;
        wait_cyc(4);
        chk("stall_no_stb", stb_cnt, s0);
        i_s_stall = 0;
        exp_s(0, 32'h80, 32'h0, 3'd4, cap + 5);
        exp_d(1, 32'h0BADF00D, 0, cap + 7);
        wait_cyc(8);
        chk("stall_one_stb", stb_cnt, s0 + 1);

        // timeout: no slave ack, then a late ack must be ignored
        slv_auto = 0;
        set_m0(0, 32'h100, 32'h0, 3'd2);
        pulse(1, 0, cap);
        exp_s(0, 32'h100, 32'h0, 3'd2, cap + 1);
        exp_d(0, 32'hFFFFFFFF, 1, cap + 17);
        wait_cyc(20);
        kick_req++;
        wait_cyc(6);
        chk("tmo_stall_clr", o_m0_stall, 0);

        // strobe while stalled is dropped
        slv_auto = 1; i_s_data = 32'h12345678;
        set_m0(0, 32'h200, 32'h0, 3'd2);
        pulse(1, 0, cap);
        exp_s(0, 32'h200, 32'h0, 3'd2, cap + 1);
        exp_d(0, 32'h12345678, 0, cap + 3);
        set_m0(1, 32'h300, 32'hAA, 3'd2);
        pulse(1, 0, s0);
        wait_cyc(8);
        chk("viol_stall_clr", o_m0_stall, 0);

        // async reset in the middle of a transaction
        slv_auto = 0;
        set_m0(0, 32'h400, 32'h0, 3'd2);
        pulse(1, 0, cap);
        exp_s(0, 32'h400, 32'h0, 3'd2, cap + 1);
        wait_cyc(3);
        #3;
        i_reset_n = 1'b0;
        #1;
        chk("arst_s_stb", o_s_stb, 0);
        chk("arst_s_addr", o_s_addr, 32'hFFFFFFFF);
        chk("arst_m0_data", o_m0_data, 32'hFFFFFFFF);
        chk("arst_grant", o_grant, 1);
        chk("arst_m0_stall", o_m0_stall, 0);
        @(posedge i_clk);
        #2;
        i_reset_n = 1'b1;
        wait_cyc(1);
        kick_req++;
        wait_cyc(6);

        chk("slave_queue_empty", sq.size(), 0);
        chk("ack_queue_empty", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
